// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces press and release,
// and hands each accepted key out through a valid/ready register with overrun flagging.
module keypad_scanner #(
   parameter int unsigned SCAN_TICKS    = 27000,
   parameter int unsigned DEBOUNCE_TIME = 54000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       key_overrun
);

   localparam int unsigned ScanW = $clog2(SCAN_TICKS) + 1;
   localparam int unsigned DbW   = $clog2(DEBOUNCE_TIME) + 1;
   localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_TICKS - 1);
   localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_TIME - 1);

   typedef enum logic [1:0] {StScan, StPressDb, StHold} state_e;

   state_e           state_q, state_d;
   logic [3:0]       row_meta_q, row_s_q;
   logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
   logic [DbW-1:0]   db_cnt_q, db_cnt_d;
   logic [3:0]       col_q, col_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             held_q, held_d;
   logic             ovr_q, ovr_d;

   logic       row_hit;
   logic       load;
   logic [1:0] low_row;
   logic [1:0] col_idx;
   logic [3:0] col_rot;

   assign row_hit = row_s_q[row_idx_q];
   assign col_rot = {col_q[2:0], col_q[3]};

   // Lowest-index pressed row wins when several keys share the driven column.
   always_comb begin
      low_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (row_s_q[i]) low_row = 2'(i);
      end
   end

   always_comb begin
      col_idx = 2'd0;
      unique case (col_q)
         4'b0001: col_idx = 2'd0;
         4'b0010: col_idx = 2'd1;
         4'b0100: col_idx = 2'd2;
         4'b1000: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      scan_cnt_d = scan_cnt_q;
      db_cnt_d   = db_cnt_q;
      col_d      = col_q;
      row_idx_d  = row_idx_q;
      held_d     = held_q;
      load       = 1'b0;
      case (state_q)
         StScan: begin
            if (scan_cnt_q == ScanLast) begin
               scan_cnt_d = '0;
               if (row_s_q == 4'b0000) begin
                  col_d = col_rot;
               end else begin
                  row_idx_d = low_row;
                  db_cnt_d  = '0;
                  state_d   = StPressDb;
               end
            end else begin
               scan_cnt_d = scan_cnt_q + 1'b1;
            end
         end
         StPressDb: begin
            if (!row_hit) begin
               state_d    = StScan;
               col_d      = col_rot;
               scan_cnt_d = '0;
            end else if (db_cnt_q == DbLast) begin
               load     = 1'b1;
               held_d   = 1'b1;
               db_cnt_d = '0;
               state_d  = StHold;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         StHold: begin
            // Only the latched row matters here; other keys are ignored until release.
            if (row_hit) begin
               db_cnt_d = '0;
            end else if (db_cnt_q == DbLast) begin
               held_d     = 1'b0;
               state_d    = StScan;
               col_d      = col_rot;
               scan_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         default: state_d = StScan;
      endcase
   end

   // A load coinciding with a transfer replaces the key rather than flagging overrun.
   always_comb begin
      code_d  = code_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (load) begin
         if (valid_q && !key_ready) begin
            ovr_d = 1'b1;
         end else begin
            code_d  = {row_idx_q, col_idx};
            valid_d = 1'b1;
         end
      end else if (valid_q && key_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= '0;
         row_s_q    <= '0;
         state_q    <= StScan;
         scan_cnt_q <= '0;
         db_cnt_q   <= '0;
         col_q      <= 4'b0001;
         row_idx_q  <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         held_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         row_meta_q <= row_i;
         row_s_q    <= row_meta_q;
         state_q    <= state_d;
         scan_cnt_q <= scan_cnt_d;
         db_cnt_q   <= db_cnt_d;
         col_q      <= col_d;
         row_idx_q  <= row_idx_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         held_q     <= held_d;
         ovr_q      <= ovr_d;
      end
   end

   assign col_o       = col_q;
   assign key_code    = code_q;
   assign key_valid   = valid_q;
   assign key_held    = held_q;
   assign key_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model driven by random and directed presses,
// with expected key codes queued at press time and checked by a handshake monitor.
module tb_keypad_scanner;

   localparam int unsigned ScanTicks = 8;
   localparam int unsigned DbTime    = 16;
   localparam int PressBound   = 4 * ScanTicks + 2 + DbTime + 1;
   localparam int ReleaseBound = DbTime + 8;

   logic       clk, rst;
   logic [3:0] row_i, col_o, key_code;
   logic       key_valid, key_ready, key_held, key_overrun;

   logic [15:0] pressed;
   logic        force_low, force_high;
   logic [1:0]  force_row;

   int errors = 0;
   int checks = 0;
   int ovr_seen = 0;
   int ovr_exp = 0;
   logic [3:0] exp_q[$];
   bit         pending = 0;
   logic [3:0] pending_code = '0;

   keypad_scanner #(
      .SCAN_TICKS   (ScanTicks),
      .DEBOUNCE_TIME(DbTime)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .row_i      (row_i),
      .col_o      (col_o),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_held   (key_held),
      .key_overrun(key_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix: a pressed key at (r,c) connects driven column c to row r.
   always_comb begin
      row_i = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && col_o[c]) row_i[r] = 1'b1;
         end
      end
      if (force_low) row_i = '0;
      if (force_high) row_i[force_row] = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every transfer must match the oldest queued key.
   always @(negedge clk) begin
      if (!rst && key_valid && key_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got code %0d expected no transfer", key_code);
         end else begin
            check("sb_code", key_code, exp_q.pop_front());
         end
      end
      if (!rst && key_overrun) ovr_seen++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_held(input logic lvl, input int bound, input string name);
      int  n   = 0;
      bit  hit = 0;
      while (!hit && n < bound) begin
         @(posedge clk);
         #1;
         n++;
         hit = (key_held === lvl);
      end
      check(name, 32'(hit), 32'd1);
   endtask

   task automatic consume();
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
      check("valid_after_transfer", 32'(key_valid), 32'd0);
      pending = 0;
   endtask

   // One press/release of key (r,c), predicting acceptance or overrun from pending state.
   task automatic press_release(input int r, input int c);
      logic [3:0] code;
      bit         exp_ovr;
      int         ovr_before;
      code       = 4'(r * 4 + c);
      exp_ovr    = pending;
      ovr_before = ovr_seen;
      if (exp_ovr) begin
         ovr_exp++;
      end else begin
         exp_q.push_back(code);
         pending      = 1;
         pending_code = code;
      end
      pressed = 16'(1) << (r * 4 + c);
      wait_held(1'b1, PressBound, "press_latency");
      check("valid_on_press", 32'(key_valid), 32'd1);
      check("code_on_press", 32'(key_code), 32'(pending_code));
      check("col_frozen", 32'(col_o), 32'(4'b0001 << c));
      tick(1 + $urandom_range(0, 10));
      check("col_still_frozen", 32'(col_o), 32'(4'b0001 << c));
      check("ovr_pulses", 32'(ovr_seen - ovr_before), exp_ovr ? 32'd1 : 32'd0);
      pressed = '0;
      wait_held(1'b0, ReleaseBound, "release_latency");
      check("col_after_release", 32'(col_o), 32'(4'b0001 << ((c + 1) % 4)));
   endtask

   task automatic do_reset_check(input string tag);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check({tag, "_col"}, 32'(col_o), 32'h1);
      check({tag, "_code"}, 32'(key_code), 32'h0);
      check({tag, "_valid"}, 32'(key_valid), 32'h0);
      check({tag, "_held"}, 32'(key_held), 32'h0);
      check({tag, "_ovr"}, 32'(key_overrun), 32'h0);
      pressed = '0;
      pending = 0;
      @(negedge clk);
      rst = 1'b0;
      begin
         bit spurious = 0;
         for (int i = 0; i < 60; i++) begin
            tick(1);
            if (key_valid || key_held) spurious = 1;
         end
         check({tag, "_no_spurious"}, 32'(spurious), 32'd0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      key_ready  = 1'b0;
      pressed    = '0;
      force_low  = 1'b0;
      force_high = 1'b0;
      force_row  = '0;
      #12;
      check("rst_col", 32'(col_o), 32'h1);
      check("rst_code", 32'(key_code), 32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_held", 32'(key_held), 32'h0);
      check("rst_ovr", 32'(key_overrun), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Idle scan: column advances every ScanTicks edges.
      for (int n = 1; n <= 64; n++) begin
         tick(1);
         check("idle_col", 32'(col_o), 32'(4'b0001 << ((n / ScanTicks) % 4)));
      end
      check("idle_valid", 32'(key_valid), 32'd0);

      // Code 9 left unconsumed, then code 0 overruns it.
      press_release(2, 1);
      press_release(0, 0);
      check("code_kept_after_ovr", 32'(key_code), 32'd9);
      consume();

      for (int t = 0; t < 8; t++) begin
         int r, c;
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         if (pending && $urandom_range(0, 1) == 1) consume();
         press_release(r, c);
      end
      if (pending) consume();

      // Bouncing press on row1/col3: nothing accepted during bounce, then one key 7.
      begin
         bit early = 0;
         pressed = 16'(1) << 7;
         for (int i = 0; i < 40; i++) begin
            force_low = (i % 5 == 4);
            tick(1);
            if (key_held || key_valid) early = 1;
         end
         force_low = 1'b0;
         check("bounce_press_rejected", 32'(early), 32'd0);
      end
      exp_q.push_back(4'd7);
      pending = 1;
      pending_code = 4'd7;
      wait_held(1'b1, PressBound, "bounce_press_accept");
      check("bounce_code", 32'(key_code), 32'd7);

      // Bouncing release: held must survive short high glitches.
      begin
         bit dropped = 0;
         pressed   = '0;
         force_row = 2'd1;
         for (int i = 0; i < 40; i++) begin
            force_high = (i % 10 == 9);
            tick(1);
            if (!key_held) dropped = 1;
         end
         force_high = 1'b0;
         check("bounce_release_held", 32'(dropped), 32'd0);
      end
      wait_held(1'b0, ReleaseBound, "bounce_release_done");
      check("resume_col0", 32'(col_o), 32'h1);
      consume();

      // Reset during press debounce.
      pressed = 16'(1) << 10;
      begin
         bit hit = 0;
         for (int i = 0; i < 40 && !hit; i++) begin
            tick(1);
            hit = (col_o == 4'b0100);
         end
         check("reach_col2", 32'(hit), 32'd1);
      end
      tick(10);
      check("in_press_db", 32'(key_held), 32'd0);
      do_reset_check("rst_pressdb");

      // Reset during hold.
      pressed = 16'(1) << 5;
      wait_held(1'b1, PressBound, "hold_before_rst");
      do_reset_check("rst_hold");

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      check("ovr_total", 32'(ovr_seen), 32'(ovr_exp));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
